// File: rtl/cdb_arbiter.sv
// Merges the ALU and LSB result streams onto one registered CDB, one broadcast per cycle.
// Latency: enqueue at edge t reaches the CDB at edge t+1 (no bypass); in_rdy=0 freezes all state.
// Backpressure: per-source combinational full flags taken from the registered count only.
module cdb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_rdy,
    input  logic              in_flush,
    input  logic              in_alu_enable,
    input  logic [ROB_W-1:0]  in_alu_reorder,
    input  logic [DATA_W-1:0] in_alu_result,
    output logic              out_alu_full,
    input  logic              in_lsb_enable,
    input  logic [ROB_W-1:0]  in_lsb_reorder,
    input  logic [DATA_W-1:0] in_lsb_result,
    output logic              out_lsb_full,
    output logic              out_cdb_enable,
    output logic [ROB_W-1:0]  out_cdb_reorder,
    output logic [DATA_W-1:0] out_cdb_result
);
    localparam int EW = ROB_W + DATA_W;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {SRC_ALU = 1'b0, SRC_LSB = 1'b1} src_e;

    // Index 0 is the ALU FIFO, index 1 the LSB FIFO.
    logic [EW-1:0]     r_mem   [2][DEPTH];
    logic [PW-1:0]     r_head  [2];
    logic [PW-1:0]     r_tail  [2];
    logic [CW-1:0]     r_count [2];
    src_e              r_last_grant;
    logic              r_cdb_enable;
    logic [ROB_W-1:0]  r_cdb_reorder;
    logic [DATA_W-1:0] r_cdb_result;

    logic [EW-1:0] w_wdat [2];
    logic [1:0]    w_full;
    logic [1:0]    w_empty;
    logic [1:0]    w_push;
    logic [1:0]    w_pop;
    logic          w_grant_alu;
    logic          w_grant_lsb;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_full[s]  = (r_count[s] == CW'(DEPTH));
            w_empty[s] = (r_count[s] == '0);
        end
        w_wdat[0] = {in_alu_reorder, in_alu_result};
        w_wdat[1] = {in_lsb_reorder, in_lsb_result};
        // Tag 0 means "no dependency" and is never worth broadcasting.
        w_push[0] = in_alu_enable && (in_alu_reorder != '0) && !w_full[0];
        w_push[1] = in_lsb_enable && (in_lsb_reorder != '0) && !w_full[1];
        w_grant_alu = !w_empty[0] && (w_empty[1] || (r_last_grant == SRC_LSB));
        w_grant_lsb = !w_empty[1] && !w_grant_alu;
        w_pop[0] = w_grant_alu;
        w_pop[1] = w_grant_lsb;
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            for (int s = 0; s < 2; s++) begin
                r_head[s]  <= '0;
                r_tail[s]  <= '0;
                r_count[s] <= '0;
            end
        end else if (in_rdy) begin
            for (int s = 0; s < 2; s++) begin
                if (in_flush) begin
                    r_head[s]  <= '0;
                    r_tail[s]  <= '0;
                    r_count[s] <= '0;
                end else begin
                    if (w_push[s]) begin
                        r_mem[s][r_tail[s]] <= w_wdat[s];
                        r_tail[s]           <= r_tail[s] + 1'b1;
                    end
                    if (w_pop[s]) begin
                        r_head[s] <= r_head[s] + 1'b1;
                    end
                    r_count[s] <= r_count[s] + CW'(w_push[s]) - CW'(w_pop[s]);
                end
            end
        end
    end

    // Idle cycles clear the valid but leave tag/data at their last broadcast value.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            r_cdb_enable  <= 1'b0;
            r_cdb_reorder <= '0;
            r_cdb_result  <= '0;
            r_last_grant  <= SRC_LSB;
        end else if (in_rdy) begin
            if (in_flush) begin
                r_cdb_enable <= 1'b0;
            end else if (w_grant_alu) begin
                r_cdb_enable                  <= 1'b1;
                {r_cdb_reorder, r_cdb_result} <= r_mem[0][r_head[0]];
                r_last_grant                  <= SRC_ALU;
            end else if (w_grant_lsb) begin
                r_cdb_enable                  <= 1'b1;
                {r_cdb_reorder, r_cdb_result} <= r_mem[1][r_head[1]];
                r_last_grant                  <= SRC_LSB;
            end else begin
                r_cdb_enable <= 1'b0;
            end
        end
    end

    assign out_alu_full    = w_full[0];
    assign out_lsb_full    = w_full[1];
    assign out_cdb_enable  = r_cdb_enable;
    assign out_cdb_reorder = r_cdb_reorder;
    assign out_cdb_result  = r_cdb_result;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboarded directed bench for cdb_arbiter: expected broadcasts (tag, data, cycle) are queued
// by the stimulus process and popped by a negedge monitor whenever the CDB is valid.
module tb_cdb_arbiter;
    localparam int DEPTH  = 4;
    localparam int ROB_W  = 4;
    localparam int DATA_W = 32;
    localparam logic [31:0] AB = 32'hA000_0000;
    localparam logic [31:0] LB = 32'hB000_0000;

    logic              in_clk = 1'b0;
    logic              in_rst_n;
    logic              in_rdy;
    logic              in_flush;
    logic              in_alu_enable;
    logic [ROB_W-1:0]  in_alu_reorder;
    logic [DATA_W-1:0] in_alu_result;
    logic              out_alu_full;
    logic              in_lsb_enable;
    logic [ROB_W-1:0]  in_lsb_reorder;
    logic [DATA_W-1:0] in_lsb_result;
    logic              out_lsb_full;
    logic              out_cdb_enable;
    logic [ROB_W-1:0]  out_cdb_reorder;
    logic [DATA_W-1:0] out_cdb_result;

    cdb_arbiter #(.DEPTH(DEPTH), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
        .in_clk          (in_clk),
        .in_rst_n        (in_rst_n),
        .in_rdy          (in_rdy),
        .in_flush        (in_flush),
        .in_alu_enable   (in_alu_enable),
        .in_alu_reorder  (in_alu_reorder),
        .in_alu_result   (in_alu_result),
        .out_alu_full    (out_alu_full),
        .in_lsb_enable   (in_lsb_enable),
        .in_lsb_reorder  (in_lsb_reorder),
        .in_lsb_result   (in_lsb_result),
        .out_lsb_full    (out_lsb_full),
        .out_cdb_enable  (out_cdb_enable),
        .out_cdb_reorder (out_cdb_reorder),
        .out_cdb_result  (out_cdb_result)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        logic [ROB_W-1:0]  tag;
        logic [DATA_W-1:0] dat;
        int                cyc;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   viol  = 0;
    int   base;
    bit   edge_live = 1'b0;

    // edge_live marks cycles whose outputs came from a non-frozen, non-reset edge.
    always @(posedge in_clk) begin
        cyc       <= cyc + 1;
        edge_live <= in_rdy && in_rst_n;
    end

    always @(negedge in_clk) begin
        if (out_cdb_enable && edge_live) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL cdb_unexpected: got tag=%0d data=%h cyc=%0d, required no broadcast",
                         out_cdb_reorder, out_cdb_result, cyc);
            end else begin
                m_e = sb.pop_front();
                if (out_cdb_reorder !== m_e.tag || out_cdb_result !== m_e.dat || cyc != m_e.cyc) begin
                    bad++;
                    $display("FAIL cdb_seq: got tag=%0d data=%h cyc=%0d, required tag=%0d data=%h cyc=%0d",
                             out_cdb_reorder, out_cdb_result, cyc, m_e.tag, m_e.dat, m_e.cyc);
                end
            end
        end
        if (in_rst_n && in_rdy && !in_flush && in_alu_enable && in_alu_reorder != '0 && out_alu_full)
            viol++;
        if (in_rst_n && in_rdy && !in_flush && in_lsb_enable && in_lsb_reorder != '0 && out_lsb_full)
            viol++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic drive(input logic ae, input logic [ROB_W-1:0] at, input logic [DATA_W-1:0] ad,
                         input logic le, input logic [ROB_W-1:0] lt, input logic [DATA_W-1:0] ld);
        in_alu_enable  = ae;
        in_alu_reorder = at;
        in_alu_result  = ad;
        in_lsb_enable  = le;
        in_lsb_reorder = lt;
        in_lsb_result  = ld;
        step();
    endtask

    task automatic idle(input int n);
        in_alu_enable = 1'b0;
        in_lsb_enable = 1'b0;
        in_flush      = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic expect_cdb(input logic [ROB_W-1:0] t, input logic [DATA_W-1:0] d, input int c);
        sb.push_back('{t, d, c});
    endtask

    task automatic do_reset(input string tag);
        in_rst_n      = 1'b0;
        in_alu_enable = 1'b0;
        in_lsb_enable = 1'b0;
        in_flush      = 1'b0;
        step();
        in_rst_n = 1'b1;
        chk({tag, "_rst_en"}, out_cdb_enable, 0);
        chk({tag, "_rst_tag"}, out_cdb_reorder, 0);
        chk({tag, "_rst_data"}, out_cdb_result, 0);
        chk({tag, "_rst_full"}, {out_alu_full, out_lsb_full}, 0);
    endtask

    initial begin
        in_rst_n = 1'b0; in_rdy = 1'b1; in_flush = 1'b0;
        in_alu_enable = 1'b0; in_alu_reorder = '0; in_alu_result = '0;
        in_lsb_enable = 1'b0; in_lsb_reorder = '0; in_lsb_result = '0;

        // Single result: two-edge latency, then valid drops while tag/data hold.
        do_reset("t1");
        base = cyc;
        expect_cdb(4'd3, 32'h0000_00AA, base + 2);
        drive(1, 4'd3, 32'h0000_00AA, 0, 0, 0);
        idle(2);
        chk("t1_en_after", out_cdb_enable, 0);
        chk("t1_tag_hold", out_cdb_reorder, 3);
        chk("t1_data_hold", out_cdb_result, 32'hAA);
        chk("t1_drained", sb.size(), 0);

        // Tie alternation: ALU wins the first tie after reset.
        do_reset("t2");
        base = cyc;
        expect_cdb(4'd1, 32'h11, base + 2);
        expect_cdb(4'd5, 32'h55, base + 3);
        expect_cdb(4'd2, 32'h22, base + 4);
        expect_cdb(4'd6, 32'h66, base + 5);
        drive(1, 4'd1, 32'h11, 1, 4'd5, 32'h55);
        drive(1, 4'd2, 32'h22, 1, 4'd6, 32'h66);
        idle(5);
        chk("t2_drained", sb.size(), 0);

        // Full boundary: both sources push every edge until ALU fills; 5th-beyond write is dropped.
        do_reset("t3");
        base = cyc;
        for (int i = 0; i < 13; i++) begin
            if (i % 2 == 0) expect_cdb(ROB_W'(1 + i / 2), AB + 32'(1 + i / 2), base + 2 + i);
            else            expect_cdb(ROB_W'(9 + i / 2), LB + 32'(9 + i / 2), base + 2 + i);
        end
        for (int k = 1; k <= 6; k++)
            drive(1, ROB_W'(k), AB + 32'(k), 1, ROB_W'(8 + k), LB + 32'(8 + k));
        chk("t3_lsb_full_e6", out_lsb_full, 1);
        chk("t3_alu_notfull_e6", out_alu_full, 0);
        drive(1, 4'd7, AB + 32'd7, 0, 0, 0);
        chk("t3_alu_full_e7", out_alu_full, 1);
        chk("t3_lsb_notfull_e7", out_lsb_full, 0);
        drive(1, 4'd8, AB + 32'd8, 0, 0, 0);
        chk("t3_alu_full_drop", out_alu_full, 0);
        idle(8);
        chk("t3_en_idle", out_cdb_enable, 0);
        chk("t3_drained", sb.size(), 0);

        // Flush with three entries in each FIFO and a concurrent tag-7 enqueue.
        do_reset("t4");
        base = cyc;
        expect_cdb(4'd1, AB + 32'd1, base + 2);
        expect_cdb(4'd9, LB + 32'd9, base + 3);
        expect_cdb(4'd2, AB + 32'd2, base + 4);
        expect_cdb(4'd10, LB + 32'd10, base + 5);
        for (int k = 1; k <= 5; k++)
            drive(1, ROB_W'(k), AB + 32'(k), 1, ROB_W'(8 + k), LB + 32'(8 + k));
        in_flush = 1'b1;
        drive(1, 4'd7, AB + 32'd7, 0, 0, 0);
        in_flush = 1'b0;
        chk("t4_en_after_flush", out_cdb_enable, 0);
        chk("t4_full_after_flush", {out_alu_full, out_lsb_full}, 0);
        idle(6);
        chk("t4_drained", sb.size(), 0);

        // Freeze with two ALU entries queued; enables during freeze must be ignored.
        do_reset("t5");
        base = cyc;
        expect_cdb(4'd4, AB + 32'd4, base + 2);
        expect_cdb(4'd12, LB + 32'd12, base + 3);
        expect_cdb(4'd5, AB + 32'd5, base + 7);
        expect_cdb(4'd6, AB + 32'd6, base + 8);
        drive(1, 4'd4, AB + 32'd4, 1, 4'd12, LB + 32'd12);
        drive(1, 4'd5, AB + 32'd5, 0, 0, 0);
        drive(1, 4'd6, AB + 32'd6, 0, 0, 0);
        in_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'd9, AB + 32'd9, 1, 4'd14, LB + 32'd14);
            chk("t5_frz_en", out_cdb_enable, 1);
            chk("t5_frz_bus", {out_cdb_reorder, out_cdb_result}, {4'd12, LB + 32'd12});
        end
        in_rdy = 1'b1;
        idle(4);
        chk("t5_en_idle", out_cdb_enable, 0);
        chk("t5_drained", sb.size(), 0);

        // Reset mid-stream (overriding freeze and flush), then a tag-0 enqueue.
        base = cyc;
        expect_cdb(4'd9, LB + 32'd9, base + 2);
        drive(1, 4'd1, AB + 32'd1, 1, 4'd9, LB + 32'd9);
        drive(1, 4'd2, AB + 32'd2, 0, 0, 0);
        in_rst_n = 1'b0; in_rdy = 1'b0; in_flush = 1'b1;
        drive(1, 4'd3, AB + 32'd3, 0, 0, 0);
        in_rst_n = 1'b1; in_rdy = 1'b1; in_flush = 1'b0;
        chk("t6_rst_en", out_cdb_enable, 0);
        chk("t6_rst_tag", out_cdb_reorder, 0);
        chk("t6_rst_data", out_cdb_result, 0);
        chk("t6_rst_full", {out_alu_full, out_lsb_full}, 0);
        drive(1, 4'd0, 32'hDEAD_BEEF, 0, 0, 0);
        idle(6);
        chk("t6_tag0_en", out_cdb_enable, 0);
        chk("t6_drained", sb.size(), 0);

        chk("overflow_flagged", viol, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the ALU and LSB result streams onto one shared common data bus (CDB) of one broadcast per cycle.
- Each source writes into its own small FIFO. A round-robin arbiter pops one entry per cycle and drives the registered CDB, which the RS, LSB and ROB all snoop.
- This replaces the dual-port broadcast scheme, so every consumer needs only one CDB snoop port.

Parameters:
- DEPTH, 4, entries per source FIFO (power of two, ≥2)
- ROB_W, 4, width of a reorder tag; tag 0 = no dependency, never broadcast
- DATA_W, 32, result width

Ports:
- in_clk  input  1  clock, rising edge
- in_rst_n  input  1  reset, synchronous, active-low
- in_rdy  input  1  global ready; low = freeze
- in_flush  input  1  misprediction clear, from ROB
- in_alu_enable  input  1  ALU result valid
- in_alu_reorder  input  ROB_W  ALU result tag
- in_alu_result  input  DATA_W  ALU result data
- out_alu_full  output  1  ALU FIFO full, combinational
- in_lsb_enable  input  1  LSB result valid
- in_lsb_reorder  input  ROB_W  LSB result tag
- in_lsb_result  input  DATA_W  LSB result data
- out_lsb_full  output  1  LSB FIFO full, combinational
- out_cdb_enable  output  1  broadcast valid, registered
- out_cdb_reorder  output  ROB_W  broadcast tag, registered
- out_cdb_result  output  DATA_W  broadcast data, registered

Behaviour:
- Reset (in_rst_n=0 at an edge):
  - both FIFOs empty (head/tail/count = 0); out_cdb_enable=0, out_cdb_reorder=0, out_cdb_result=0.
  - Round-robin pointer last_grant=LSB, so the ALU wins the first tie.
  - Reset overrides in_flush and in_rdy. Reset mid-stream discards all queued entries with no broadcast.
- Freeze (in_rdy=0, not reset): all state and outputs hold. Enables are ignored.
- Flush (in_flush=1, in_rdy=1): both FIFOs are emptied. out_cdb_enable=0 on the next cycle. last_grant holds.
  - An enqueue in the same cycle is discarded; flush wins.
- Enqueue: at an edge with in_rdy=1, no flush, in_X_enable=1 and in_X_reorder!=0, the {reorder, result} pair is written at the tail.
  - A tag of 0 is ignored.
  - Enqueue while out_X_full=1 is a protocol violation. The entry is dropped and the bench asserts on it.
- out_X_full = (count_X == DEPTH). It is computed from registered count only, with no same-cycle pop credit.
- Grant, evaluated on the state at each edge (in_rdy=1, no flush):
  - Both FIFOs non-empty: grant the source != last_grant.
  - Only one non-empty: grant it.
  - Neither non-empty: no grant; out_cdb_enable<=0, and tag/data hold their old values.
- On grant:
  - head entry popped; out_cdb_enable<=1; out_cdb_reorder/out_cdb_result <= head entry.
  - last_grant <= granted source.
- Latency: a result enqueued at edge t into an empty FIFO, with no contention, is broadcast in the cycle after edge t+1. There is no combinational bypass.
- Under contention, a source waits at most one extra grant slot per queued entry ahead of it (strict alternation).
- Simultaneous enqueue and pop on the same FIFO in one edge is legal: count unchanged, pointers both advance.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH and needs log2(DEPTH)+1 bits.
- Ordering: within one source, FIFO order is preserved. Across sources, order is set only by arbitration.
- Throughput: sustained 1 broadcast/cycle while any FIFO is non-empty.

Test Plan:
- Single result: after reset, ALU enqueues tag 3 / data 0x0000_00AA at edge 1 → out_cdb_enable=1, tag 3, data 0xAA in the cycle after edge 2; enable=0 the cycle after.
- Tie alternation: ALU {1,0x11}, {2,0x22} and LSB {5,0x55}, {6,0x66}, both enqueued in two consecutive edges → CDB sequence tags 1,5,2,6 on four consecutive cycles with matching data.
- Full boundary (DEPTH=4): enqueue 4 ALU results while a continuous LSB stream holds the grant... (the bench keeps the LSB FIFO non-empty) → out_alu_full=1 after the 4th write. A 5th write is flagged by the assertion and never broadcast. Full drops the cycle after the first ALU pop.
- Flush: 3 entries queued in each FIFO, flush pulsed with a concurrent ALU enqueue of tag 7 → next cycle out_cdb_enable=0, both full flags 0, and tag 7 never appears.
- Freeze: hold in_rdy=0 for 3 cycles with 2 ALU entries queued → outputs are constant and the enables are ignored. After in_rdy=1 returns, both entries broadcast on consecutive cycles.
- Reset mid-stream plus tag-0 filtering: assert in_rst_n=0 with entries queued → next cycle all outputs 0 and the FIFOs empty. After reset, an ALU enqueue with tag 0 produces no broadcast.
